// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the unified-memory port arbiter:
//   FSM state encoding, store-type codes, requester ids and the record
//   latched when a request is accepted.
package mem_arb_pkg;

  // Storage width of the latched request. Port widths of the arbiter may be
  // narrower; the fields are zero-extended on capture and truncated on use.
  localparam int ARB_AW = 64;
  localparam int ARB_DW = 64;

  localparam logic [1:0] ST_BYTE  = 2'b00;
  localparam logic [1:0] ST_HALF  = 2'b01;
  localparam logic [1:0] ST_WORD  = 2'b10;
  localparam logic [1:0] ST_DWORD = 2'b11;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [1:0]        store_type;
    logic              lock;
    logic              id;
  } arb_req_t;

endpackage

// File: rtl/arb_rr_select.sv
// arb_rr_select
//   Combinational 2-way pick for the memory port arbiter.
//   i_req        : request vector (bit n = requester n)
//   i_lock       : per-requester lock request
//   i_ptr        : requester favoured on a tie
//   i_owner_vld  : a lock owner exists
//   i_owner      : lock owner id
//   i_burst_exh  : owner has used up its burst allowance
//   o_gnt        : one-hot grant (or zero when nobody requests)
module arb_rr_select (
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  input  logic       i_ptr,
  input  logic       i_owner_vld,
  input  logic       i_owner,
  input  logic       i_burst_exh,
  output logic [1:0] o_gnt
);

  logic w_hold;

  // The owner keeps the port only while it still requests with lock held
  // and has burst budget left; otherwise fall back to round-robin.
  assign w_hold = i_owner_vld && i_req[i_owner] && i_lock[i_owner] && !i_burst_exh;

  always_comb begin
    o_gnt = 2'b00;
    if (w_hold)       o_gnt[i_owner] = 1'b1;
    else if (&i_req)  o_gnt[i_ptr]   = 1'b1;
    else              o_gnt          = i_req;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port unified memory between the core (requester 0)
//   and the debug/program loader (requester 1). Round-robin arbitration with
//   optional bursting lock, each access sequenced IDLE -> ACCESS ->
//   (WAIT x READ_LATENCY -> RESP for reads) -> IDLE.
//   Ports:
//     clk, arstn                 clock, async active-low reset
//     i_req_n/i_we_n/i_addr_n/i_wdata_n/i_store_type_n/i_lock_n  request n
//     o_gnt_n                    request accepted (IDLE only, combinational)
//     o_rvalid_n/o_rdata_n       one-cycle read strobe, data held afterwards
//     o_mem_*                    memory command, i_mem_read_data read return
//     o_busy                     FSM not in IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_req_0,
  input  logic                  i_req_1,
  input  logic                  i_we_0,
  input  logic                  i_we_1,
  input  logic [ADDR_WIDTH-1:0] i_addr_0,
  input  logic [ADDR_WIDTH-1:0] i_addr_1,
  input  logic [DATA_WIDTH-1:0] i_wdata_0,
  input  logic [DATA_WIDTH-1:0] i_wdata_1,
  input  logic [1:0]            i_store_type_0,
  input  logic [1:0]            i_store_type_1,
  input  logic                  i_lock_0,
  input  logic                  i_lock_1,
  output logic                  o_gnt_0,
  output logic                  o_gnt_1,
  output logic                  o_rvalid_0,
  output logic                  o_rvalid_1,
  output logic [DATA_WIDTH-1:0] o_rdata_0,
  output logic [DATA_WIDTH-1:0] o_rdata_1,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  output logic [1:0]            o_mem_store_type,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic                  o_busy
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_t            r_state, w_next;
  arb_req_t              r_req;
  logic [2:0]            r_wcnt;
  logic                  r_ptr;
  logic                  r_owner_vld;
  logic                  r_owner;
  logic [BCW-1:0]        r_bcnt;
  logic [DATA_WIDTH-1:0] r_rdata_0, r_rdata_1;

  logic [1:0] w_req, w_lock, w_sel, w_gnt;
  logic       w_idle, w_win, w_burst_exh, w_owner_keep, w_drive;

  assign w_req        = {i_req_1, i_req_0};
  assign w_lock       = {i_lock_1, i_lock_0};
  assign w_idle       = (r_state == S_IDLE);
  assign w_burst_exh  = (r_bcnt >= BCW'(MAX_BURST));
  assign w_owner_keep = w_req[r_owner] & w_lock[r_owner];

  arb_rr_select u_sel (
    .i_req       (w_req),
    .i_lock      (w_lock),
    .i_ptr       (r_ptr),
    .i_owner_vld (r_owner_vld),
    .i_owner     (r_owner),
    .i_burst_exh (w_burst_exh),
    .o_gnt       (w_sel)
  );

  assign w_gnt = w_idle ? w_sel : 2'b00;
  assign w_win = w_gnt[1];

  // state register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (|w_gnt) w_next = S_ACCESS;
      S_ACCESS: w_next = r_req.we ? S_IDLE : S_WAIT;
      S_WAIT:   if (r_wcnt == 3'd0) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_req       <= '0;
      r_wcnt      <= '0;
      r_ptr       <= 1'b0;
      r_owner_vld <= 1'b0;
      r_owner     <= 1'b0;
      r_bcnt      <= '0;
      r_rdata_0   <= '0;
      r_rdata_1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_gnt) begin
            r_req.we         <= w_win ? i_we_1 : i_we_0;
            r_req.addr       <= ARB_AW'(w_win ? i_addr_1 : i_addr_0);
            r_req.wdata      <= ARB_DW'(w_win ? i_wdata_1 : i_wdata_0);
            r_req.store_type <= w_win ? i_store_type_1 : i_store_type_0;
            r_req.lock       <= w_lock[w_win];
            r_req.id         <= w_win;
            r_ptr            <= ~w_win;
          end else if (r_owner_vld && !w_owner_keep) begin
            // owner let go while nobody else was granted
            r_owner_vld <= 1'b0;
            r_bcnt      <= '0;
          end
        end
        S_ACCESS: begin
          r_wcnt <= 3'(READ_LATENCY - 1);
          // Ownership follows the latched lock. A grant continues the burst
          // only if it went to the same owner without exhausting the budget;
          // an exhausted owner that wins round-robin starts a fresh burst.
          if (r_req.lock) begin
            r_owner_vld <= 1'b1;
            r_owner     <= r_req.id;
            r_bcnt      <= (r_owner_vld && (r_owner == r_req.id) && !w_burst_exh)
                           ? r_bcnt + 1'b1 : BCW'(1);
          end else begin
            r_owner_vld <= 1'b0;
            r_bcnt      <= '0;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt - 1'b1;
          if (r_wcnt == 3'd0) begin
            if (r_req.id == REQ_DBG) r_rdata_1 <= i_mem_read_data;
            else                     r_rdata_0 <= i_mem_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  // The command is presented in ACCESS and kept stable through WAIT.
  assign w_drive          = (r_state == S_ACCESS) || (r_state == S_WAIT);
  assign o_mem_addr       = w_drive ? r_req.addr[ADDR_WIDTH-1:0] : '0;
  assign o_mem_write_data = w_drive ? r_req.wdata[DATA_WIDTH-1:0] : '0;
  assign o_mem_store_type = w_drive ? r_req.store_type : ST_BYTE;
  assign o_mem_write_en   = (r_state == S_ACCESS) && r_req.we;

  assign o_gnt_0    = w_gnt[0];
  assign o_gnt_1    = w_gnt[1];
  assign o_rvalid_0 = (r_state == S_RESP) && (r_req.id == REQ_CORE);
  assign o_rvalid_1 = (r_state == S_RESP) && (r_req.id == REQ_DBG);
  assign o_rdata_0  = r_rdata_0;
  assign o_rdata_1  = r_rdata_1;
  assign o_busy     = !w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Three arbiters (READ_LATENCY 1, 3, 4; MAX_BURST 4) share one stimulus
//   stream. Each has its own fixed-latency memory and a transaction-level
//   model; every cycle all outputs are compared, and literal expectations
//   at known cycles pin the model.
module tb_mem_port_arbiter;

  localparam int NI = 3;
  localparam int MB = 4;
  localparam int HL = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn;
  logic        req0, req1, we0, we1, lk0, lk1;
  logic [63:0] addr0, addr1, wd0, wd1;
  logic [1:0]  st0, st1;

  logic        g0_v [NI], g1_v [NI], rv0_v [NI], rv1_v [NI], we_v [NI], busy_v [NI];
  logic [63:0] ma_v [NI], mwd_v [NI], rd0_v [NI], rd1_v [NI], mrd_v [NI];
  logic [1:0]  mst_v [NI];

  int rl [NI] = '{1, 3, 4};
  int cyc, n_chk, n_err;

  // memory contents
  function automatic logic [63:0] memf(input logic [63:0] a);
    if (a == 64'h100) return 64'hDEAD_BEEF;
    return {a[31:0] ^ 32'hC0FF_EE00, ~a[31:0]};
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int RLK = (k == 0) ? 1 : (k == 1) ? 3 : 4;
    // read data for the address presented RLK cycles earlier
    logic [63:0] pipe [0:3] = '{default: 64'h0};
    always @(posedge clk) begin
      pipe[0] <= ma_v[k];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mrd_v[k] = memf(pipe[RLK-1]);

    mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64),
                       .READ_LATENCY(RLK), .MAX_BURST(MB)) u_dut (
      .clk(clk), .arstn(arstn),
      .i_req_0(req0), .i_req_1(req1), .i_we_0(we0), .i_we_1(we1),
      .i_addr_0(addr0), .i_addr_1(addr1), .i_wdata_0(wd0), .i_wdata_1(wd1),
      .i_store_type_0(st0), .i_store_type_1(st1), .i_lock_0(lk0), .i_lock_1(lk1),
      .o_gnt_0(g0_v[k]), .o_gnt_1(g1_v[k]), .o_rvalid_0(rv0_v[k]), .o_rvalid_1(rv1_v[k]),
      .o_rdata_0(rd0_v[k]), .o_rdata_1(rd1_v[k]), .o_mem_write_en(we_v[k]),
      .o_mem_addr(ma_v[k]), .o_mem_write_data(mwd_v[k]), .o_mem_store_type(mst_v[k]),
      .i_mem_read_data(mrd_v[k]), .o_busy(busy_v[k])
    );
  end

  // model state: current transaction, arbitration state, held read data
  int          m_free [NI], m_g [NI], m_bcnt [NI];
  bit          m_last [NI], m_ov [NI], m_own [NI], m_we [NI], m_id [NI];
  logic [63:0] m_addr [NI], m_wd [NI], m_rd0 [NI], m_rd1 [NI];
  logic [1:0]  m_st [NI];

  // sampled DUT history for the literal checks
  bit          h_g0 [NI][HL], h_g1 [NI][HL], h_rv0 [NI][HL], h_rv1 [NI][HL];
  bit          h_we [NI][HL], h_busy [NI][HL];
  logic [63:0] h_ma [NI][HL], h_rd0 [NI][HL], h_wd [NI][HL];

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      bit [1:0] rq, lkv;
      bit hold, eg0, eg1, edrv, ewe, erv;
      int w, d;
      eg0 = 0; eg1 = 0;
      rq  = {req1, req0};
      lkv = {lk1, lk0};
      if (!arstn) begin
        m_free[k] = 0; m_g[k] = -1000; m_bcnt[k] = 0; m_last[k] = 1;
        m_ov[k] = 0; m_own[k] = 0; m_we[k] = 0; m_id[k] = 0;
        m_addr[k] = '0; m_wd[k] = '0; m_st[k] = '0; m_rd0[k] = '0; m_rd1[k] = '0;
      end else if (cyc >= m_free[k]) begin
        w = -1;
        if (m_ov[k] && !(rq[m_own[k]] && lkv[m_own[k]])) begin m_ov[k] = 0; m_bcnt[k] = 0; end
        hold = m_ov[k] && (m_bcnt[k] < MB);
        if (hold)             w = int'(m_own[k]);
        else if (rq == 2'b11) w = m_last[k] ? 0 : 1;
        else if (rq[0])       w = 0;
        else if (rq[1])       w = 1;
        if (w >= 0) begin
          eg0 = (w == 0); eg1 = (w == 1);
          m_g[k]    = cyc;
          m_id[k]   = w[0];
          m_we[k]   = w[0] ? we1 : we0;
          m_addr[k] = w[0] ? addr1 : addr0;
          m_wd[k]   = w[0] ? wd1 : wd0;
          m_st[k]   = w[0] ? st1 : st0;
          if (lkv[w[0]]) begin
            m_bcnt[k] = hold ? m_bcnt[k] + 1 : 1;
            m_ov[k] = 1; m_own[k] = w[0];
          end else begin
            m_ov[k] = 0; m_bcnt[k] = 0;
          end
          m_last[k] = w[0];
          m_free[k] = m_we[k] ? cyc + 2 : cyc + 3 + rl[k];
        end
      end
      d    = cyc - m_g[k];
      edrv = (d == 1) || (!m_we[k] && d >= 1 && d <= 1 + rl[k]);
      ewe  = m_we[k] && (d == 1);
      erv  = !m_we[k] && (d == 2 + rl[k]);
      if (erv) begin
        if (m_id[k]) m_rd1[k] = memf(m_addr[k]);
        else         m_rd0[k] = memf(m_addr[k]);
      end
      chk("gnt0",   k, 64'(g0_v[k]),   64'(eg0));
      chk("gnt1",   k, 64'(g1_v[k]),   64'(eg1));
      chk("rvalid0", k, 64'(rv0_v[k]), 64'(erv && !m_id[k]));
      chk("rvalid1", k, 64'(rv1_v[k]), 64'(erv && m_id[k]));
      chk("mem_we", k, 64'(we_v[k]),   64'(ewe));
      chk("busy",   k, 64'(busy_v[k]), 64'(d >= 1 && cyc < m_free[k]));
      chk("mem_addr",  k, ma_v[k],  edrv ? m_addr[k] : 64'h0);
      chk("mem_wdata", k, mwd_v[k], edrv ? m_wd[k] : 64'h0);
      chk("mem_st",    k, 64'(mst_v[k]), edrv ? 64'(m_st[k]) : 64'h0);
      chk("rdata0", k, rd0_v[k], m_rd0[k]);
      chk("rdata1", k, rd1_v[k], m_rd1[k]);
      if (cyc < HL) begin
        h_g0[k][cyc] = g0_v[k];   h_g1[k][cyc] = g1_v[k];
        h_rv0[k][cyc] = rv0_v[k]; h_rv1[k][cyc] = rv1_v[k];
        h_we[k][cyc] = we_v[k];   h_busy[k][cyc] = busy_v[k];
        h_ma[k][cyc] = ma_v[k];   h_rd0[k][cyc] = rd0_v[k]; h_wd[k][cyc] = mwd_v[k];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int t, t2;
    bit any;
    arstn = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lk0 = 0; lk1 = 0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0; st0 = '0; st1 = '0;
    cyc = 0; n_chk = 0; n_err = 0;
    @(posedge clk); #1;
    run(3);
    chk("reset_busy", 0, 64'(busy_v[0]), 64'h0);
    chk("reset_rdata0", 0, rd0_v[0], 64'h0);
    arstn = 1;
    run(2);

    // single read
    t = cyc;
    req0 = 1; we0 = 0; addr0 = 64'h100; st0 = 2'b11;
    run(1); req0 = 0; run(8);
    chk("L_rd_gnt0", 0, 64'(h_g0[0][t]), 64'h1);
    chk("L_rd_addr1", 0, h_ma[0][t+1], 64'h100);
    chk("L_rd_addr2", 0, h_ma[0][t+2], 64'h100);
    chk("L_rd_rv0", 0, 64'(h_rv0[0][t+3]), 64'h1);
    chk("L_rd_data", 0, h_rd0[0][t+3], 64'hDEAD_BEEF);
    chk("L_rl4_rv_early", 2, 64'(h_rv0[2][t+5]), 64'h0);
    chk("L_rl4_addr", 2, h_ma[2][t+5], 64'h100);
    chk("L_rl4_rv", 2, 64'(h_rv0[2][t+6]), 64'h1);

    // single write
    t = cyc;
    req1 = 1; we1 = 1; addr1 = 64'h200; wd1 = 64'h55; st1 = 2'b00;
    run(1); req1 = 0; run(4);
    chk("L_wr_gnt1", 0, 64'(h_g1[0][t]), 64'h1);
    chk("L_wr_we", 0, 64'(h_we[0][t+1]), 64'h1);
    chk("L_wr_addr", 0, h_ma[0][t+1], 64'h200);
    chk("L_wr_data", 0, h_wd[0][t+1], 64'h55);
    chk("L_wr_we_off", 0, 64'(h_we[0][t+2]), 64'h0);
    chk("L_wr_busy_off", 0, 64'(h_busy[0][t+2]), 64'h0);
    any = 0;
    for (int c = t; c < t + 5; c++) any |= h_rv1[0][c] | h_rv0[0][c];
    chk("L_wr_no_rvalid", 0, 64'(any), 64'h0);

    // contention from reset, both writing
    arstn = 0; run(1); arstn = 1;
    t = cyc;
    req0 = 1; we0 = 1; addr0 = 64'h300; wd0 = 64'h11; st0 = 2'b11;
    req1 = 1; we1 = 1; addr1 = 64'h308; wd1 = 64'h22; st1 = 2'b10;
    run(8); req0 = 0; req1 = 0; run(2);
    chk("L_ct_g0a", 0, 64'(h_g0[0][t]), 64'h1);
    chk("L_ct_gap", 0, 64'(h_g0[0][t+1] | h_g1[0][t+1]), 64'h0);
    chk("L_ct_g1a", 0, 64'(h_g1[0][t+2]), 64'h1);
    chk("L_ct_g0b", 0, 64'(h_g0[0][t+4]), 64'h1);
    chk("L_ct_g1b", 0, 64'(h_g1[0][t+6]), 64'h1);

    // lock burst by requester 1, requester 0 contending
    arstn = 0; run(1); arstn = 1;
    t = cyc;
    req1 = 1; we1 = 1; lk1 = 1; addr1 = 64'h500; wd1 = 64'h66;
    run(1);
    req0 = 1; we0 = 1; lk0 = 0; addr0 = 64'h508; wd0 = 64'h77;
    run(12); lk1 = 0; run(3);
    req0 = 0; req1 = 0; run(3);
    for (int i = 0; i < 4; i++) chk($sformatf("L_lk_g1_%0d", i), 0, 64'(h_g1[0][t+2*i]), 64'h1);
    chk("L_lk_g0_forced", 0, 64'(h_g0[0][t+8]), 64'h1);
    chk("L_lk_g1_new", 0, 64'(h_g1[0][t+10]), 64'h1);
    chk("L_lk_g1_cont", 0, 64'(h_g1[0][t+12]), 64'h1);
    chk("L_lk_drop_g0", 0, 64'(h_g0[0][t+14]), 64'h1);

    // reset in the middle of a READ_LATENCY=3 read
    t = cyc;
    req0 = 1; we0 = 0; lk0 = 0; addr0 = 64'h400; st0 = 2'b10;
    run(1); req0 = 0; run(2);
    arstn = 0; #1;
    chk("L_mid_busy", 1, 64'(busy_v[1]), 64'h0);
    chk("L_mid_addr", 1, ma_v[1], 64'h0);
    run(2); arstn = 1; run(8);
    any = 0;
    for (int c = t + 3; c < t + 13; c++) any |= h_rv0[1][c];
    chk("L_mid_no_rvalid", 1, 64'(any), 64'h0);
    t2 = cyc;
    req0 = 1; run(1); req0 = 0; run(8);
    chk("L_mid_reissue_rv", 1, 64'(h_rv0[1][t2+5]), 64'h1);
    chk("L_mid_reissue_data", 1, h_rd0[1][t2+5], memf(64'h400));

    // mixed reads under contention with a lock on requester 0
    req0 = 1; we0 = 0; lk0 = 1; addr0 = 64'h600; st0 = 2'b01;
    req1 = 1; we1 = 0; lk1 = 0; addr1 = 64'h700; st1 = 2'b11;
    run(30);
    lk0 = 0; we1 = 1; wd1 = 64'h1234;
    run(15);
    req0 = 0; req1 = 0; run(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between two requesters. Requester 0 is the core's instruction-fetch/load-store path. Requester 1 is the debug/program loader. The block sits between the requesters and the memory unit. It arbitrates round-robin, with optional lock for bursts, and sequences each access through a fixed-latency read pipeline. Each requester gets a one-cycle accept and a one-cycle read-data strobe.

Parameters:
ADDR_WIDTH, 64, memory address width
DATA_WIDTH, 64, memory data width
READ_LATENCY, 1, cycles from ACCESS cycle until i_mem_read_data is valid (legal 1..4)
MAX_BURST, 8, max consecutive grants to a locking requester before a forced arbitration

Ports:
clk  in  1  clock
arstn  in  1  asynchronous active-low reset
i_req_0 / i_req_1  in  1  access request
i_we_0 / i_we_1  in  1  1=write, 0=read
i_addr_0 / i_addr_1  in  ADDR_WIDTH  byte address
i_wdata_0 / i_wdata_1  in  DATA_WIDTH  write data
i_store_type_0 / i_store_type_1  in  2  00 byte, 01 half, 10 word, 11 dword
i_lock_0 / i_lock_1  in  1  keep ownership after this access
o_gnt_0 / o_gnt_1  out  1  request accepted this cycle
o_rvalid_0 / o_rvalid_1  out  1  read data valid, one cycle
o_rdata_0 / o_rdata_1  out  DATA_WIDTH  read data, held until next rvalid for that port
o_mem_write_en  out  1  memory write strobe
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_write_data  out  DATA_WIDTH  memory write data
o_mem_store_type  out  2  memory store type
i_mem_read_data  in  DATA_WIDTH  memory read data
o_busy  out  1  state != IDLE

Behaviour:
- Reset state: IDLE, RR pointer favours requester 0, burst count 0, lock owner none.
  - All outputs are 0 at reset.
  - Reset is asynchronous at any time, including mid-access. The in-flight access is dropped, with no rvalid and no write. Requesters re-issue.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE, cycle T:
  - Select a winner among the asserted i_req_n.
  - Assert o_gnt_winner combinationally in cycle T.
  - Latch we/addr/wdata/store_type/lock and the winner id. Next state is ACCESS.
  - No request: stay in IDLE; o_mem_* are 0.
- ACCESS, T+1: drive o_mem_addr, o_mem_write_data and o_mem_store_type from the latch.
  - Write: o_mem_write_en=1 for this cycle only, then IDLE. A new grant is possible at T+2.
  - Read: go to WAIT.
- WAIT: count READ_LATENCY cycles with o_mem_addr held stable.
  - In the last WAIT cycle (T+1+READ_LATENCY), register i_mem_read_data into o_rdata_winner. Next state is RESP.
- RESP, T+2+READ_LATENCY: o_rvalid_winner=1 for exactly one cycle, then IDLE.
- o_gnt_n is never asserted outside IDLE. o_rvalid_0 and o_rvalid_1 are never both high. Writes never produce rvalid.
- Requester protocol:
  - Fields must be stable while i_req_n is high and not yet granted.
  - Dropping i_req_n before grant withdraws the request.
  - After grant, the requester may present its next request immediately; it is considered at the next IDLE.
- Arbitration:
  - Both requesting, no lock: grant the requester not granted last. The pointer updates on every grant.
  - Lock: if the latched lock=1, the owner is that requester. At subsequent IDLE cycles only the owner may be granted, while it keeps i_req and i_lock high. Each owner grant increments the burst count.
  - When the count reaches MAX_BURST, the next arbitration ignores lock and uses plain round-robin. The count resets to 0 on owner change or lock drop.
  - Owner drops i_req or i_lock: ownership is released in that same IDLE cycle, with normal round-robin.
- Single requester: granted with no bubbles beyond the access sequence. Read throughput is one access per READ_LATENCY+3 cycles.

Decomposition:
- Package mem_arb_pkg:
  - state enum typedef (IDLE, ACCESS, WAIT, RESP).
  - store-type localparams (ST_BYTE..ST_DWORD).
  - requester id localparams (REQ_CORE=0, REQ_DBG=1).
  - latched-request struct (we, addr, wdata, store_type, lock, id).
- Sub-module arb_rr_select: combinational 2-way pick from req, pointer, lock owner and burst-exhausted flag; outputs the one-hot grant. The FSM, counters and pointer register live in the top.

Test Plan:
- Single read, READ_LATENCY=1: req_0 read addr 0x100 in cycle 0, memory returns 0xDEADBEEF at 0x100 → gnt_0 in cycle 0; o_mem_addr=0x100 in cycles 1-2; rvalid_0 in cycle 3 with rdata_0=0xDEADBEEF.
- Write: req_1 we=1 addr 0x200 wdata 0x55 store_type 00 → gnt_1 in cycle 0; o_mem_write_en=1 only in cycle 1, with addr 0x200 and data 0x55; no rvalid; busy low in cycle 2.
- Contention: both request writes continuously from reset → grants alternate 0,1,0,1, with each grant 2 cycles apart.
- Lock burst, MAX_BURST=4: req_1 lock=1 with req_0 also continuously requesting → the first four accepted accesses (initial grant plus burst grants) go to requester 1, then gnt_0; dropping lock earlier hands over at the next IDLE.
- Reset mid-read, READ_LATENCY=3: arstn low in the WAIT state → outputs 0 immediately; no rvalid after release; re-issued read completes normally.
- Latency sweep: READ_LATENCY=4 → rvalid exactly 6 cycles after gnt, with the address stable throughout.
